// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic matrix-multiply core.
// Holds the default array geometry, the controller state encoding and the
// arithmetic helpers used by the PEs (saturating accumulate) and by the
// output stage (quantise to element width, threshold activation).
// The helpers work on 64-bit containers; callers widen their operands and
// truncate the result to their own parameterised width.
package systolic_pkg;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned AW_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // acc + inc, clamped to 2^aw-1 instead of wrapping
  function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                          input logic [63:0] inc,
                                          input int unsigned aw);
    logic [63:0] lim;
    logic [64:0] sum;
    lim = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
    sum = {1'b0, acc} + {1'b0, inc};
    if (sum > {1'b0, lim}) return lim;
    return sum[63:0];
  endfunction

  // min(acc, 2^dw-1)
  function automatic logic [63:0] quantise(input logic [63:0] acc,
                                           input int unsigned dw);
    logic [63:0] lim;
    lim = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
    return (acc > lim) ? lim : acc;
  endfunction

  // pass q when it reaches the threshold, else zero; th = 0 passes everything
  function automatic logic [63:0] activate(input logic [63:0] q,
                                           input logic [63:0] th);
    return (q >= th) ? q : '0;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element of the output-stationary array.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clr         - synchronous accumulator clear (job start without keep)
//   en          - accumulate enable (array active)
//   a_in, b_in  - operands arriving from the left / from above
//   a_out,b_out - operands forwarded right / down, one cycle later
//   acc         - saturating accumulator of a_in*b_in
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  logic [2*DW-1:0] prod;

  always_comb begin
    prod = (2*DW)'(a_in) * (2*DW)'(b_in);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= AW'(sat_add(64'(acc), 64'(prod), AW));
      end
    end
  end

endmodule

// File: rtl/systolic_mm_core.sv
// N x N output-stationary systolic matrix multiplier, C = act(quant(A*B)).
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   start      - job request, honoured only when idle
//   acc_keep   - with start: keep accumulators (chain partial sums)
//   a_mat      - A(i,k) at [(i*N+k)*DW +: DW]
//   b_mat      - B(k,j) at [(k*N+j)*DW +: DW]
//   thresh     - with start: activation threshold (0 disables)
//   busy       - job in progress
//   done       - one-cycle pulse when c_mat is updated
//   c_mat      - C(i,j) at [(i*N+j)*DW +: DW], held until the next done
// Timing: start accepted at edge E0, done/c_mat at edge E0+3N+1.
module systolic_mm_core
  import systolic_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              acc_keep,
  input  logic [N*N*DW-1:0] a_mat,
  input  logic [N*N*DW-1:0] b_mat,
  input  logic [DW-1:0]     thresh,
  output logic              busy,
  output logic              done,
  output logic [N*N*DW-1:0] c_mat
);

  localparam int unsigned MW        = N*N*DW;
  localparam int unsigned RUN_LAST  = 3*N - 3;
  localparam int unsigned DRAIN_END = 3*N;
  localparam int unsigned SW        = $clog2(3*N + 1);

  state_t           state;
  logic [SW-1:0]    step;
  int unsigned      step_i;
  logic [MW-1:0]    a_reg;
  logic [MW-1:0]    b_reg;
  logic [DW-1:0]    thresh_reg;
  logic [MW-1:0]    c_next;
  logic             clr;
  logic             en;

  logic [DW-1:0]    a_nxt  [N];
  logic [DW-1:0]    b_nxt  [N];
  logic [DW-1:0]    a_feed [N];
  logic [DW-1:0]    b_feed [N];
  logic [DW-1:0]    a_h    [N][N+1];
  logic [DW-1:0]    b_v    [N+1][N];
  logic [AW-1:0]    acc_w  [N][N];

  assign step_i = 32'(step);

  always_comb begin
    clr = (state == ST_IDLE) && start && !acc_keep;
    en  = (state != ST_IDLE);
  end

  // Skewed edge feed: row i carries A(i, step-i), column j carries
  // B(step-j, j); zero outside each operand's window and outside RUN.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      a_nxt[i] = '0;
      b_nxt[i] = '0;
      if ((state == ST_RUN) && (step_i >= i) && (step_i - i < N)) begin
        a_nxt[i] = a_reg[(i*N + (step_i - i))*DW +: DW];
        b_nxt[i] = b_reg[((step_i - i)*N + i)*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        a_feed[i] <= '0;
        b_feed[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        a_feed[i] <= a_nxt[i];
        b_feed[i] <= b_nxt[i];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_edge
    assign a_h[i][0] = a_feed[i];
    assign b_v[0][i] = b_feed[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(
        .DW(DW),
        .AW(AW)
      ) u_pe (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .acc   (acc_w[i][j])
      );
    end
  end

  always_comb begin
    c_next = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        c_next[(i*N + j)*DW +: DW] =
          DW'(activate(quantise(64'(acc_w[i][j]), DW), 64'(thresh_reg)));
      end
    end
  end

  // The step counter keeps running through FLUSH so the last product can
  // cross the array (it lands at E0+3N-1) before c_mat is captured at E0+3N+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      step       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      c_mat      <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      thresh_reg <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_RUN;
            step       <= '0;
            busy       <= 1'b1;
            a_reg      <= a_mat;
            b_reg      <= b_mat;
            thresh_reg <= thresh;
          end
        end
        ST_RUN: begin
          step <= step + SW'(1);
          if (step_i == RUN_LAST) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (step_i == DRAIN_END) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            c_mat <= c_next;
          end else begin
            step <= step + SW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mm_core.sv
// Self-checking bench for systolic_mm_core (N=4, DW=8, AW=24).
// A job-level model (matrix product, saturating accumulators, quantise,
// threshold, fixed 3N+1 latency) is compared against busy/done/c_mat on
// every falling edge; directed tests add literal expectations.
module tb_systolic_mm_core;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 24;
  localparam int unsigned MW = N*N*DW;
  localparam longint ACC_MAX = (64'sd1 <<< AW) - 1;
  localparam longint Q_MAX   = (64'sd1 <<< DW) - 1;

  localparam logic [MW-1:0] C_PATTERN = 128'h100F0E0D_0C0B0A09_08070605_04030201;
  localparam logic [MW-1:0] C_ALL_FF  = {16{8'hFF}};
  localparam logic [MW-1:0] C_ALL_16  = {16{8'h10}};
  localparam logic [MW-1:0] C_DIAG2   = 128'h02000000_00020000_00000200_00000002;
  localparam logic [MW-1:0] C_DIAG1   = 128'h01000000_00010000_00000100_00000001;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          acc_keep = 1'b0;
  logic [MW-1:0] a_mat = '0;
  logic [MW-1:0] b_mat = '0;
  logic [DW-1:0] thresh = '0;
  logic          busy;
  logic          done;
  logic [MW-1:0] c_mat;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  int A [N][N];
  int B [N][N];

  int            m_left = 0;
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [MW-1:0] m_c = '0;
  logic [MW-1:0] m_pend = '0;
  longint        m_acc [N][N];

  systolic_mm_core #(
    .N (N),
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .acc_keep(acc_keep),
    .a_mat   (a_mat),
    .b_mat   (b_mat),
    .thresh  (thresh),
    .busy    (busy),
    .done    (done),
    .c_mat   (c_mat)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- job-level model ----
  function automatic longint acc_after(input int i, input int j);
    longint s;
    s = acc_keep ? m_acc[i][j] : 0;
    for (int k = 0; k < N; k++) s += longint'(A[i][k]) * longint'(B[k][j]);
    return (s > ACC_MAX) ? ACC_MAX : s;
  endfunction

  function automatic logic [DW-1:0] out_elem(input longint acc);
    longint q;
    q = (acc > Q_MAX) ? Q_MAX : acc;
    return (q >= longint'(thresh)) ? DW'(q) : '0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_c    <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) m_acc[i][j] <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_left <= 3*N + 1;
          m_busy <= 1'b1;
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
              m_acc[i][j] <= acc_after(i, j);
              m_pend[(i*N + j)*DW +: DW] <= out_elem(acc_after(i, j));
            end
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_c    <= m_pend;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", MW'(busy), MW'(m_busy));
      cmp("done", MW'(done), MW'(m_done));
      cmp("c_mat", c_mat, m_c);
    end
  end

  // kind: 0 identity, 1 pattern 4r+c+1, 2 constant v
  task automatic load(input int ka, input int va, input int kb, input int vb);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        A[r][c] = (ka == 0) ? int'(r == c) : (ka == 1) ? 4*r + c + 1 : va;
        B[r][c] = (kb == 0) ? int'(r == c) : (kb == 1) ? 4*r + c + 1 : vb;
        a_mat[(r*N + c)*DW +: DW] = DW'(A[r][c]);
        b_mat[(r*N + c)*DW +: DW] = DW'(B[r][c]);
      end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done in 40 cycles, expected one");
    end
    #1;
  endtask

  // Called 2 time units after a rising edge; returns at the same phase.
  task automatic run_job(input bit keep, input logic [DW-1:0] th, output int lat);
    acc_keep = keep;
    thresh   = th;
    start    = 1'b1;
    @(posedge clk);
    #1 cmp("accept", MW'(busy), MW'(1));
    #1 start = 1'b0;
    wait_done(lat);
  endtask

  initial begin
    int lat;
    int ndone;

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_busy", MW'(busy), MW'(0));
    cmp("rst_done", MW'(done), MW'(0));
    cmp("rst_c", c_mat, '0);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // identity x pattern, first edge after reset
    load(0, 0, 1, 0);
    run_job(1'b0, 8'd0, lat);
    cmp("lat_ident", MW'(lat), MW'(13));
    cmp("c_ident", c_mat, C_PATTERN);

    // all 255: quantise saturation, raw accumulator 4*255*255
    load(2, 255, 2, 255);
    run_job(1'b0, 8'd0, lat);
    cmp("c_255", c_mat, C_ALL_FF);
    cmp("acc00_255", MW'(dut.g_row[0].g_col[0].u_pe.acc), MW'(260100));
    cmp("acc33_255", MW'(dut.g_row[3].g_col[3].u_pe.acc), MW'(260100));

    // chain 64 more jobs: accumulator must clamp at 2^24-1
    for (int r = 0; r < 64; r++) run_job(1'b1, 8'd0, lat);
    cmp("acc_sat", MW'(dut.g_row[1].g_col[2].u_pe.acc), MW'(24'hFFFFFF));
    cmp("c_sat", c_mat, C_ALL_FF);

    // threshold boundary: every element is 16
    load(2, 2, 2, 2);
    run_job(1'b0, 8'd17, lat);
    cmp("c_th17", c_mat, '0);
    run_job(1'b0, 8'd16, lat);
    cmp("c_th16", c_mat, C_ALL_16);

    // K-tiling: identity twice with keep on the second job
    load(0, 0, 0, 0);
    run_job(1'b0, 8'd0, lat);
    cmp("c_keep1", c_mat, C_DIAG1);
    run_job(1'b1, 8'd0, lat);
    cmp("c_keep2", c_mat, C_DIAG2);

    // start while busy is ignored; start right after done is taken
    load(0, 0, 1, 0);
    acc_keep = 1'b0;
    thresh   = 8'd0;
    start    = 1'b1;
    @(posedge clk);
    #1 cmp("accept5", MW'(busy), MW'(1));
    #1 start = 1'b0;
    ndone = 0;
    lat   = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        lat = c;
      end
      if (c == 14) cmp("b2b_accept", MW'(busy), MW'(1));
      #1;
      if (c == 2 || c == 11) begin
        start = 1'b1; acc_keep = 1'b1; thresh = 8'd200;
      end else if (c == 13) begin
        start = 1'b1; acc_keep = 1'b0; thresh = 8'd0;
      end else begin
        start = 1'b0;
      end
    end
    cmp("single_done", MW'(ndone), MW'(1));
    cmp("lat_busy", MW'(lat), MW'(13));
    cmp("c_busy", c_mat, C_PATTERN);
    wait_done(lat);
    cmp("lat_b2b", MW'(lat), MW'(13));
    cmp("c_b2b", c_mat, C_PATTERN);

    // reset in RUN step 5, then a keep job must start from zero
    load(2, 2, 2, 2);
    acc_keep = 1'b0;
    thresh   = 8'd0;
    start    = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    cmp("mid_rst_busy", MW'(busy), MW'(0));
    cmp("mid_rst_c", c_mat, '0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    load(0, 0, 0, 0);
    run_job(1'b1, 8'd0, lat);
    cmp("lat_post_rst", MW'(lat), MW'(13));
    cmp("c_post_rst", c_mat, C_DIAG1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected finish before 300000");
    $fatal(1);
  end

endmodule
